alu_md: RTL and testbench

Parametrised successor to the single-cycle ALU: a WIDTH-bit execute unit that runs the standard ALUFun operations with one cycle of latency and adds iterative multiply/divide (signed and unsigned) producing a HI/LO pair. It sits in the EX stage. The pipeline stalls on `in_ready` low while a multiply or divide is iterating. Results are returned on a registered valid pulse.

---
 rtl/alu_md.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_md.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// EX-stage execute unit: single-cycle ALUFun operations plus iterative
// radix-2 multiply/divide (signed and unsigned) returning a HI/LO pair.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             md_en,
    input  logic [1:0]       md_op,
    input  logic [5:0]       ALUFun,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] hi,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam int MSB = WIDTH - 1;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] md_hi_reg;
    logic [WIDTH-1:0] md_lo_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic [WIDTH-1:0] a_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             dz_reg;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] hi_reg;
    logic             out_valid_reg;

    logic accept;

    assign in_ready  = (state_reg == IDLE) & ~reset;
    assign busy      = (state_reg != IDLE);
    assign accept    = in_valid & in_ready;
    assign S         = s_reg;
    assign hi        = hi_reg;
    assign out_valid = out_valid_reg;

    // Adder shared by add/sub and compare; compares always subtract.
    logic             sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] add_res;
    logic             flag_z;
    logic             v_signed;
    logic             flag_n;

    assign sub      = (ALUFun[5:4] == 2'b11) | ALUFun[0];
    assign b_op     = sub ? ~B : B;
    assign sum      = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    assign add_res  = sum[MSB:0];
    assign flag_z   = (add_res == '0);
    assign v_signed = (A[MSB] == b_op[MSB]) & (add_res[MSB] != A[MSB]);
    // Signed N corrects the raw sign bit by overflow; unsigned N is the borrow.
    assign flag_n   = Sign ? (add_res[MSB] ^ v_signed) : (sub & ~sum[WIDTH]);

    logic             sel_and, sel_or, sel_xor, sel_nor, sel_pass;
    logic [WIDTH-1:0] logic_res;

    assign sel_and  = (ALUFun[3:0] == 4'b1000);
    assign sel_or   = (ALUFun[3:0] == 4'b1110);
    assign sel_xor  = (ALUFun[3:0] == 4'b0110);
    assign sel_nor  = (ALUFun[3:0] == 4'b0001);
    assign sel_pass = (ALUFun[3:0] == 4'b1010);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign logic_res[gi] = (sel_and  & (A[gi] & B[gi]))
                                 | (sel_or   & (A[gi] | B[gi]))
                                 | (sel_xor  & (A[gi] ^ B[gi]))
                                 | (sel_nor  & ~(A[gi] | B[gi]))
                                 | (sel_pass & A[gi]);
        end
    endgenerate

    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] shift_res;

    assign shamt = A[CW-1:0];

    always_comb begin
        shift_res = B;
        case (ALUFun[1:0])
            2'b00:   shift_res = B << shamt;
            2'b01:   shift_res = B >> shamt;
            2'b11:   shift_res = $signed(B) >>> shamt;
            default: shift_res = B;
        endcase
    end

    logic a_zero;
    logic cmp_bit;

    assign a_zero = (A == '0);

    always_comb begin
        cmp_bit = 1'b0;
        case (ALUFun[3:1])
            3'b001:  cmp_bit = flag_z;
            3'b000:  cmp_bit = ~flag_z;
            3'b010:  cmp_bit = flag_n;
            3'b110:  cmp_bit = A[MSB] | a_zero;
            3'b101:  cmp_bit = A[MSB];
            3'b111:  cmp_bit = ~A[MSB] & ~a_zero;
            default: cmp_bit = 1'b0;
        endcase
    end

    logic [WIDTH-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        case (ALUFun[5:4])
            2'b00:   alu_res = add_res;
            2'b01:   alu_res = logic_res;
            2'b10:   alu_res = shift_res;
            default: alu_res = {{(WIDTH-1){1'b0}}, cmp_bit};
        endcase
    end

    // Operand magnitudes for the iterative core; unsigned ops never negate.
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_op = ~md_op[0];
    assign a_neg     = signed_op & A[MSB];
    assign b_neg     = signed_op & B[MSB];
    assign a_mag     = a_neg ? (~A + WIDTH'(1)) : A;
    assign b_mag     = b_neg ? (~B + WIDTH'(1)) : B;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign mul_sum   = {1'b0, md_hi_reg} + (md_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign div_shift = {md_hi_reg, md_lo_reg[MSB]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign prod      = {md_hi_reg, md_lo_reg};
    assign prod_fix  = neg_q_reg ? (~prod + (2*WIDTH)'(1)) : prod;
    assign quo_fix   = neg_q_reg ? (~md_lo_reg + WIDTH'(1)) : md_lo_reg;
    assign rem_fix   = neg_r_reg ? (~md_hi_reg + WIDTH'(1)) : md_hi_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_reg        <= '0;
            md_hi_reg     <= '0;
            md_lo_reg     <= '0;
            opnd_reg      <= '0;
            a_reg         <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            dz_reg        <= 1'b0;
            s_reg         <= '0;
            hi_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (md_en) begin
                            op_reg    <= md_op;
                            md_hi_reg <= '0;
                            md_lo_reg <= a_mag;
                            opnd_reg  <= b_mag;
                            a_reg     <= A;
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                            dz_reg    <= (B == '0);
                            cnt_reg   <= '0;
                            state_reg <= RUN;
                        end else begin
                            s_reg         <= alu_res;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (op_reg[1]) begin
                        // Restoring step: keep the trial difference only if it did not go negative.
                        if (!div_diff[WIDTH]) begin
                            md_hi_reg <= div_diff[MSB:0];
                            md_lo_reg <= {md_lo_reg[MSB-1:0], 1'b1};
                        end else begin
                            md_hi_reg <= div_shift[MSB:0];
                            md_lo_reg <= {md_lo_reg[MSB-1:0], 1'b0};
                        end
                    end else begin
                        md_hi_reg <= mul_sum[WIDTH:1];
                        md_lo_reg <= {mul_sum[0], md_lo_reg[MSB:1]};
                    end
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= FIN;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                FIN: begin
                    if (!op_reg[1]) begin
                        {hi_reg, s_reg} <= prod_fix;
                    end else if (dz_reg) begin
                        s_reg  <= '1;
                        hi_reg <= a_reg;
                    end else begin
                        s_reg  <= quo_fix;
                        hi_reg <= rem_fix;
                    end
                    out_valid_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: 32-bit and 8-bit instances, expected results
// queued at issue time and compared when out_valid pulses.
module tb_alu_md;

    localparam int W  = 32;
    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_valid, md_en, sign, in_ready, out_valid, busy;
    logic [1:0]    md_op;
    logic [5:0]    fun;
    logic [W-1:0]  a, b, s, hi;

    logic          in_valid8, md_en8, sign8, in_ready8, out_valid8, busy8;
    logic [1:0]    md_op8;
    logic [5:0]    fun8;
    logic [W8-1:0] a8, b8, s8, hi8;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .md_en(md_en), .md_op(md_op), .ALUFun(fun), .Sign(sign), .A(a), .B(b),
        .out_valid(out_valid), .S(s), .hi(hi), .busy(busy)
    );

    alu_md #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .md_en(md_en8), .md_op(md_op8), .ALUFun(fun8), .Sign(sign8), .A(a8), .B(b8),
        .out_valid(out_valid8), .S(s8), .hi(hi8), .busy(busy8)
    );

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] hi;
        logic         chk_hi;
        string        tag;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;
    bit   seen32, seen8;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle; outputs sampled on the falling edge, queued results popped.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        seen32 = 1'b0;
        seen8  = 1'b0;
        if (out_valid === 1'b1) begin
            seen32 = 1'b1;
            if (q32.size() == 0) chk1("spurious_valid32", out_valid, 1'b0);
            else begin
                e = q32.pop_front();
                $display("result32 %s S=%h hi=%h", e.tag, s, hi);
                chk({e.tag, "_S"}, s, e.s);
                if (e.chk_hi) chk({e.tag, "_hi"}, hi, e.hi);
            end
        end
        if (out_valid8 === 1'b1) begin
            seen8 = 1'b1;
            if (q8.size() == 0) chk1("spurious_valid8", out_valid8, 1'b0);
            else begin
                e = q8.pop_front();
                $display("result8 %s S=%h hi=%h", e.tag, s8, hi8);
                chk({e.tag, "_S"}, {24'h0, s8}, e.s);
                if (e.chk_hi) chk({e.tag, "_hi"}, {24'h0, hi8}, e.hi);
            end
        end
    endtask

    task automatic push(input bit w8, input string tag, input logic [W-1:0] es,
                        input logic [W-1:0] eh, input logic ch);
        exp_t e;
        e.s = es; e.hi = eh; e.chk_hi = ch; e.tag = tag;
        if (w8) q8.push_back(e);
        else    q32.push_back(e);
    endtask

    task automatic alu_go(input string tag, input logic [5:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic sg, input logic [W-1:0] es);
        in_valid = 1'b1; md_en = 1'b0; fun = f; a = x; b = y; sign = sg;
        push(1'b0, tag, es, '0, 1'b0);
        tick();
        chk1({tag, "_valid"}, seen32, 1'b1);
    endtask

    task automatic wait_seen(input bit w8, input string tag);
        int lat;
        lat = 1;
        while (!(w8 ? seen8 : seen32) && lat < 60) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, (w8 ? W8 : W) + 2);
    endtask

    task automatic md_go(input string tag, input logic [1:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] es, input logic [W-1:0] eh);
        in_valid = 1'b1; md_en = 1'b1; md_op = op; a = x; b = y;
        push(1'b0, tag, es, eh, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_seen(1'b0, tag);
    endtask

    task automatic md8_go(input string tag, input logic [1:0] op, input logic [W8-1:0] x,
                          input logic [W8-1:0] y, input logic [W8-1:0] es, input logic [W8-1:0] eh);
        in_valid8 = 1'b1; md_en8 = 1'b1; md_op8 = op; a8 = x; b8 = y;
        push(1'b1, tag, {24'h0, es}, {24'h0, eh}, 1'b1);
        tick();
        in_valid8 = 1'b0;
        wait_seen(1'b1, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad;
        reset = 1'b1;
        in_valid = 0; md_en = 0; md_op = 0; fun = 0; sign = 0; a = 0; b = 0;
        in_valid8 = 0; md_en8 = 0; md_op8 = 0; fun8 = 0; sign8 = 0; a8 = 0; b8 = 0;
        repeat (3) tick();
        chk1("ready_in_reset", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("reset_S", s, '0);
        chk("reset_hi", hi, '0);
        chk1("reset_valid", out_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("ready_after_reset", in_ready, 1'b1);

        // Single-cycle ALU ops, issued back to back every cycle.
        alu_go("add_ovf", 6'b000000, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h80000000);
        alu_go("sub",     6'b000001, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE);
        alu_go("lt_s",    6'b110101, 32'd5, 32'd7, 1'b1, 32'h1);
        alu_go("lt_u",    6'b110101, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0);
        alu_go("lt_s_neg",6'b110101, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1);
        alu_go("lt_s_ovf",6'b110101, 32'h80000000, 32'h1, 1'b1, 32'h1);
        alu_go("and",     6'b011000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000);
        alu_go("or",      6'b011110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hFFF0FFF0);
        alu_go("sra",     6'b100011, 32'd4, 32'h80000000, 1'b0, 32'hF8000000);
        alu_go("nor",     6'b010001, 32'hF0F0F0F0, 32'h0F0F0F00, 1'b0, 32'h0000000F);
        alu_go("xor",     6'b010110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0);
        alu_go("pass_a",  6'b011010, 32'h12345678, 32'hFFFFFFFF, 1'b0, 32'h12345678);
        alu_go("logic_undef", 6'b011111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0);
        alu_go("sll_lowbits", 6'b100000, 32'h24, 32'h1, 1'b0, 32'h10);
        alu_go("srl",     6'b100001, 32'h1, 32'h80000000, 1'b0, 32'h40000000);
        alu_go("shift_none", 6'b100010, 32'h3, 32'hABCD, 1'b0, 32'hABCD);
        alu_go("eq",      6'b110011, 32'd9, 32'd9, 1'b1, 32'h1);
        alu_go("ne_same", 6'b110001, 32'd9, 32'd9, 1'b1, 32'h0);
        alu_go("ne_diff", 6'b110001, 32'd9, 32'd8, 1'b1, 32'h1);
        alu_go("lez",     6'b111100, 32'h0, 32'h0, 1'b1, 32'h1);
        alu_go("ltz",     6'b111010, 32'h80000000, 32'h0, 1'b1, 32'h1);
        alu_go("gtz_zero",6'b111110, 32'h0, 32'h0, 1'b1, 32'h0);
        alu_go("gtz_pos", 6'b111110, 32'd5, 32'h0, 1'b1, 32'h1);
        in_valid = 1'b0;
        tick();
        chk1("valid_drops", out_valid, 1'b0);

        // Signed multiply with a competing request held throughout the stall.
        in_valid = 1'b1; md_en = 1'b1; md_op = 2'b00; a = 32'hFFFFFFFD; b = 32'd7;
        push(1'b0, "mult_neg", 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b1);
        tick();
        md_en = 1'b0; fun = 6'b000000; a = 32'd1; b = 32'd1;
        bad = 0;
        lat = 1;
        if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
        while (!seen32 && lat < 60) begin
            tick();
            lat++;
            if (!seen32 && (in_ready !== 1'b0 || busy !== 1'b1)) bad++;
        end
        in_valid = 1'b0;
        chk("mult_latency", lat, W + 2);
        chk("mult_stall_cycles_bad", bad, 0);
        chk1("mult_ready_after", in_ready, 1'b1);

        md_go("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        md_go("div_negb",  2'b10, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1);
        md_go("divu_zero", 2'b11, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7);
        md_go("div_zero",  2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);
        md_go("div_minm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
        md_go("divu",      2'b11, 32'd64, 32'd7, 32'd9, 32'd1);
        md_go("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);

        alu_go("add_keep_hi", 6'b000000, 32'd1, 32'd1, 1'b0, 32'd2);
        in_valid = 1'b0;
        chk("hi_held", hi, 32'hFFFFFFFE);

        // Reset in RUN cycle 10 of a MULTU: no result, registers cleared.
        in_valid = 1'b1; md_en = 1'b1; md_op = 2'b01; a = 32'h12345678; b = 32'h9ABCDEF0;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        chk1("rst_run_busy", busy, 1'b0);
        chk1("rst_run_valid", out_valid, 1'b0);
        chk1("rst_run_ready", in_ready, 1'b0);
        chk("rst_run_S", s, '0);
        chk("rst_run_hi", hi, '0);
        reset = 1'b0;
        alu_go("after_reset", 6'b000001, 32'd10, 32'd3, 1'b0, 32'd7);
        in_valid = 1'b0;
        repeat (40) tick();

        // 8-bit build.
        md8_go("multu8", 2'b01, 8'hFF, 8'hFF, 8'h01, 8'hFE);
        md8_go("mult8",  2'b00, 8'hFF, 8'hFF, 8'h01, 8'h00);
        md8_go("div8_minm1", 2'b10, 8'h80, 8'hFF, 8'h80, 8'h00);
        in_valid8 = 1'b1; md_en8 = 1'b0; fun8 = 6'b100000; a8 = 8'h0B; b8 = 8'h01; sign8 = 1'b0;
        push(1'b1, "sll8_lowbits", 32'h08, '0, 1'b0);
        tick();
        chk1("sll8_valid", seen8, 1'b1);
        in_valid8 = 1'b0;
        repeat (3) tick();

        chk("q32_drained", 32'(q32.size()), 0);
        chk("q8_drained", 32'(q8.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
